// File: rtl/jk_reg_sequencer.sv
// Command-driven JK register bank sequencer; q updates 1 cycle after accept (N cycles for counted ops), done 1 cycle later.
// Backpressure: cmd_ready is high only in IDLE; cmd_valid while busy is ignored, so the host holds it until accepted.
module jk_reg_sequencer #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic [CNT_W-1:0] cmd_cnt,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] j_bus,
  output logic [WIDTH-1:0] k_bus,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  localparam logic [2:0] OP_LOAD   = 3'd1;
  localparam logic [2:0] OP_CLEAR  = 3'd2;
  localparam logic [2:0] OP_SET    = 3'd3;
  localparam logic [2:0] OP_TOGGLE = 3'd4;
  localparam logic [2:0] OP_SHL    = 3'd5;
  localparam logic [2:0] OP_CNTUP  = 3'd6;

  state_t           state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] next_val;
  logic             cmd_multi;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      op_q    <= '0;
      data_q  <= '0;
      rem_q   <= '0;
      q_q     <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      data_q  <= data_d;
      rem_q   <= rem_d;
      q_q     <= q_d;
    end
  end

  // J/K only leave zero in EXEC; the JK storage then follows Qn = J&~Q | ~K&Q.
  always_comb begin
    j_bus    = '0;
    k_bus    = '0;
    next_val = '0;
    if (state_q == EXEC) begin
      case (op_q)
        OP_LOAD: begin
          j_bus = data_q;
          k_bus = ~data_q;
        end
        OP_CLEAR:  k_bus = '1;
        OP_SET:    j_bus = '1;
        OP_TOGGLE: begin
          j_bus = data_q;
          k_bus = data_q;
        end
        OP_SHL: begin
          next_val = {q_q[WIDTH-2:0], data_q[0]};
          j_bus    = next_val;
          k_bus    = ~next_val;
        end
        OP_CNTUP: begin
          next_val = q_q + WIDTH'(1);
          j_bus    = next_val;
          k_bus    = ~next_val;
        end
        default: begin
          j_bus = '0;
          k_bus = '0;
        end
      endcase
    end
    q_d = (j_bus & ~q_q) | (~k_bus & q_q);
  end

  assign cmd_multi = (cmd_op == OP_SHL) || (cmd_op == OP_CNTUP);

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    data_d  = data_q;
    rem_d   = rem_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          op_d   = cmd_op;
          data_d = cmd_data;
          if (!cmd_multi) begin
            rem_d   = CNT_W'(1);
            state_d = EXEC;
          end else if (cmd_cnt == '0) begin
            // Zero-count repeat ops skip EXEC so q is never touched.
            rem_d   = '0;
            state_d = DONE;
          end else begin
            rem_d   = cmd_cnt;
            state_d = EXEC;
          end
        end
      end
      EXEC: begin
        rem_d = rem_q - CNT_W'(1);
        if (rem_q == CNT_W'(1)) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign q         = q_q;
  assign cmd_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);

endmodule

// File: tb/tb_jk_reg_sequencer.sv
// Directed bench for jk_reg_sequencer: expected q at each done pulse is queued by the
// stimulus and checked by an independent monitor; cycle-level details are checked inline.
module tb_jk_reg_sequencer;

  localparam int WIDTH = 4;
  localparam int CNT_W = 4;

  localparam logic [2:0] OP_NOP    = 3'd0;
  localparam logic [2:0] OP_LOAD   = 3'd1;
  localparam logic [2:0] OP_CLEAR  = 3'd2;
  localparam logic [2:0] OP_SET    = 3'd3;
  localparam logic [2:0] OP_TOGGLE = 3'd4;
  localparam logic [2:0] OP_SHL    = 3'd5;
  localparam logic [2:0] OP_CNTUP  = 3'd6;
  localparam logic [2:0] OP_RSVD   = 3'd7;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [2:0]       cmd_op = '0;
  logic [WIDTH-1:0] cmd_data = '0;
  logic [CNT_W-1:0] cmd_cnt = '0;
  logic [WIDTH-1:0] q, j_bus, k_bus;
  logic             busy, done;

  int n_checks = 0;
  int n_fail   = 0;
  logic [WIDTH-1:0] exp_q[$];

  jk_reg_sequencer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_data(cmd_data), .cmd_cnt(cmd_cnt), .q(q),
    .j_bus(j_bus), .k_bus(k_bus), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, got, want);
    end
  endtask

  // Monitor: every done pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!reset && done) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_done: got done with q=%0h, expected no done", q);
      end else begin
        check("q_at_done", 32'(q), 32'(exp_q.pop_front()));
      end
    end
  end

  // Waits for cmd_ready (bounded), presents the command for exactly one accepting edge.
  task automatic send(input logic [2:0] op, input logic [WIDTH-1:0] data,
                      input logic [CNT_W-1:0] cnt);
    int n = 0;
    @(negedge clk);
    while (!cmd_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check("ready_timeout", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = data;
    cmd_cnt   = cnt;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_data  = '1;
    cmd_cnt   = '1;
  endtask

  // Raises cmd_valid immediately even while busy and holds it until acceptance.
  task automatic send_hold(input logic [2:0] op, input logic [WIDTH-1:0] data);
    int n = 0;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = data;
    cmd_cnt   = '0;
    while (!cmd_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check("hold_timeout", 32'(cmd_ready), 32'd1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  initial begin
    // Reset state
    #12;
    check("rst_q", 32'(q), 32'h0);
    check("rst_ready", 32'(cmd_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_jk", 32'({j_bus, k_bus}), 32'h00);
    @(negedge clk);
    reset = 1'b0;

    // LOAD 1001: J/K visible during EXEC
    exp_q.push_back(4'b1001);
    send(OP_LOAD, 4'b1001, '0);
    @(negedge clk);
    check("load_j", 32'(j_bus), 32'b1001);
    check("load_k", 32'(k_bus), 32'b0110);
    check("load_busy", 32'(busy), 32'd1);
    check("load_ready", 32'(cmd_ready), 32'd0);

    // TOGGLE / CLEAR / SET
    exp_q.push_back(4'b1100);
    send(OP_TOGGLE, 4'b0101, '0);
    exp_q.push_back(4'b0000);
    send(OP_CLEAR, 4'b0000, '0);
    exp_q.push_back(4'b1111);
    send(OP_SET, 4'b0000, '0);

    // SHIFT_L cnt=2 serial-in 1 from 1001
    exp_q.push_back(4'b1001);
    send(OP_LOAD, 4'b1001, '0);
    exp_q.push_back(4'b0111);
    send(OP_SHL, 4'b0001, 4'd2);
    @(negedge clk);
    check("shl_step0_q", 32'(q), 32'b1001);
    @(negedge clk);
    check("shl_step1_q", 32'(q), 32'b0011);
    check("shl_step1_done", 32'(done), 32'd0);
    check("shl_step1_busy", 32'(busy), 32'd1);
    @(negedge clk);
    check("shl_done_busy", 32'(busy), 32'd1);
    check("shl_done", 32'(done), 32'd1);
    @(negedge clk);
    check("shl_after_busy", 32'(busy), 32'd0);

    // COUNT_UP with wrap, then cnt=0
    exp_q.push_back(4'hE);
    send(OP_LOAD, 4'hE, '0);
    exp_q.push_back(4'h1);
    send(OP_CNTUP, 4'h0, 4'd3);
    @(negedge clk);
    check("cnt_e", 32'(q), 32'hE);
    @(negedge clk);
    check("cnt_f", 32'(q), 32'hF);
    @(negedge clk);
    check("cnt_wrap", 32'(q), 32'h0);
    exp_q.push_back(4'h1);
    send(OP_CNTUP, 4'h0, 4'd0);
    @(negedge clk);
    check("cnt0_done", 32'(done), 32'd1);
    check("cnt0_q", 32'(q), 32'h1);

    // LOAD held during COUNT_UP, then reserved opcode
    exp_q.push_back(4'h5);
    send(OP_CNTUP, 4'h0, 4'd4);
    exp_q.push_back(4'b0110);
    send_hold(OP_LOAD, 4'b0110);
    exp_q.push_back(4'b0110);
    send(OP_RSVD, 4'b1111, '0);
    exp_q.push_back(4'b0110);
    send(OP_NOP, 4'b1111, '0);

    // Async reset in the middle of COUNT_UP cnt=8
    send(OP_CNTUP, 4'h0, 4'd8);
    @(posedge clk);
    @(posedge clk);
    @(posedge clk);
    #1;
    check("pre_rst_q", 32'(q), 32'h9);
    #2;
    reset = 1'b1;
    #1;
    check("arst_q", 32'(q), 32'h0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_done", 32'(done), 32'd0);
    check("arst_ready", 32'(cmd_ready), 32'd1);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (12) @(negedge clk);
    check("post_rst_ready", 32'(cmd_ready), 32'd1);
    check("post_rst_q", 32'(q), 32'h0);
    check("pending_dones", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected test completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/jk_reg_sequencer.md
Name: jk_reg_sequencer

Overview:
Command-driven controller for a WIDTH-bit register bank built from JK flip-flops. It accepts one operation at a time over a valid/ready handshake and sequences the per-bit J/K controls over one or more cycles: load, clear, set, toggle, shift-left and count-up. It sits between a host command source and the JK storage, and exports both the register value and the J/K buses it applies.

Parameters:
WIDTH, 4, register bank width in bits (>=2)
CNT_W, 4, width of the repeat count for multi-cycle ops

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset; clears all state
cmd_valid  input  1  command present
cmd_ready  output  1  controller can accept a command (high only in IDLE)
cmd_op  input  3  opcode, see Behaviour
cmd_data  input  WIDTH  load value / toggle mask / serial-in bit (bit 0)
cmd_cnt  input  CNT_W  repeat count for SHIFT_L and COUNT_UP
q  output  WIDTH  register bank contents
j_bus  output  WIDTH  J inputs applied this cycle
k_bus  output  WIDTH  K inputs applied this cycle
busy  output  1  high in EXEC and DONE
done  output  1  one-cycle pulse on command completion

Behaviour:
- Reset (async, any time): q=0, state=IDLE, done=0, internal op/data/count regs=0. j_bus=k_bus=0. cmd_ready=1 and busy=0 once state is IDLE. No command can be accepted while reset is high.
- Every q bit obeys JK rules each clock edge: J=0,K=0 hold; J=0,K=1 clear; J=1,K=0 set; J=1,K=1 toggle.
- FSM states: IDLE, EXEC, DONE.
  - IDLE: cmd_ready=1, j_bus=k_bus=0. On an edge with cmd_valid=1, latch op, data and cnt.
    - Single-cycle op: remaining=1, go to EXEC.
    - SHIFT_L or COUNT_UP with cmd_cnt=0: go directly to DONE; q is unchanged.
    - Otherwise: remaining=cmd_cnt, go to EXEC.
  - EXEC: j_bus/k_bus driven combinationally from the latched op and the current q. q updates on every edge and remaining decrements. The edge on which remaining==1 moves to DONE.
  - DONE: done=1 for exactly one cycle, cmd_ready=0, j/k=0. The next edge returns to IDLE.
- Opcodes and the J/K they drive in EXEC:
  - 0 NOP: J=K=0; 1 cycle.
  - 1 LOAD: J=data, K=~data; 1 cycle.
  - 2 CLEAR: J=0, K=all ones; 1 cycle.
  - 3 SET: J=all ones, K=0; 1 cycle.
  - 4 TOGGLE: J=K=data (mask); 1 cycle.
  - 5 SHIFT_L: next={q[WIDTH-2:0], data[0]}, J=next, K=~next; cnt cycles. The MSB is discarded.
  - 6 COUNT_UP: next=q+1 mod 2^WIDTH, J=next, K=~next; cnt cycles. Wraps all-ones to 0 silently.
  - 7 reserved: executes as NOP, including its done pulse.
- Timing:
  - A single-cycle op accepted at edge T0 updates q at T1. done is high from T1 to T2, and cmd_ready is high again after T2.
  - A command with count N updates q at T1..TN; done is high from TN to TN+1.
  - Minimum spacing between commands is 3 cycles for single-cycle ops and 2 cycles for cnt=0.
- cmd_valid while busy: ignored; nothing is latched. The host must hold cmd_valid until it sees cmd_ready.
- Input stability: cmd_data and cmd_cnt are only sampled at acceptance, so changes during EXEC have no effect.
- Reset mid-operation: the command is aborted, no done pulse is issued, and q=0.
- busy = (state != IDLE); cmd_ready = (state == IDLE).

Test Plan:
- Reset then LOAD data=4'b1001 -> cmd_ready=1 after reset, q=0; q=1001 one cycle after acceptance; j_bus=1001, k_bus=0110 during EXEC; done pulses once.
- From q=1001, TOGGLE data=0101 -> q=1100; then CLEAR -> q=0000; then SET -> q=1111, each with one done pulse.
- From q=1001, SHIFT_L cnt=2 data[0]=1 -> q=0011 after the first EXEC edge, 0111 after the second; busy for 3 cycles; done on the cycle after the last update.
- LOAD 4'hE, then COUNT_UP cnt=3 -> q sequence E, F, 0, 1 (wrap checked). Then COUNT_UP cnt=0 -> no q change, done pulse one cycle after acceptance.
- Hold cmd_valid high with LOAD 0110 during a COUNT_UP -> command is not taken until cmd_ready=1, then q=0110. opcode 7 -> q unchanged, done=1 once.
- Assert reset asynchronously (mid-cycle) during COUNT_UP cnt=8 after 3 steps -> q=0 immediately, no done pulse, IDLE with cmd_ready=1 after release.
